cpu_req_tx: RTL and testbench

//  CPU-side transmitter for the cpu_to_control_req_if request channel.
//  - Accepts host commands on a valid/ready port and queues them in a 2-entry FIFO.
//  - Presents queue entries in order on req_if; the control request buffer consumes

---
 rtl/cpu_req_tx.sv | 82 ++++++++
 tb/tb_cpu_req_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cpu_req_tx.sv
// cpu_req_tx: 2-entry FIFO that validates host commands and presents them on the registered req_if channel.
package cpu_req_tx_pkg;
  localparam int ADDR_W = 10;
  localparam int ADDR_W_ENCODING_W = 3;
  localparam int CPU_OPCODE_W = 2;
  localparam logic [CPU_OPCODE_W-1:0] AES_DEC = 2'd0;
  localparam logic [CPU_OPCODE_W-1:0] AES_ENC = 2'd1;
  typedef struct packed {
    logic [ADDR_W-1:0] text_addr;
    logic [ADDR_W_ENCODING_W-1:0] text_width;
    logic [ADDR_W-1:0] key_addr;
    logic [CPU_OPCODE_W-1:0] opcode;
    logic valid;
  } cpu_to_control_req_if;
endpackage

module cpu_req_tx #(
  parameter int ADDR_W = cpu_req_tx_pkg::ADDR_W,
  parameter int ADDR_W_ENCODING_W = cpu_req_tx_pkg::ADDR_W_ENCODING_W,
  parameter int CPU_OPCODE_W = cpu_req_tx_pkg::CPU_OPCODE_W,
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [ADDR_W-1:0] cmd_text_addr,
  input  logic [ADDR_W_ENCODING_W-1:0] cmd_text_width,
  input  logic [ADDR_W-1:0] cmd_key_addr,
  input  logic [CPU_OPCODE_W-1:0] cmd_opcode,
  output cpu_req_tx_pkg::cpu_to_control_req_if req_if,
  input  logic req_ready,
  input  logic clr_err,
  output logic err_bad_cmd,
  output logic err_timeout,
  output logic busy,
  output logic [15:0] issued_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  localparam logic [TIMEOUT_W-1:0] T_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] T_PRE = T_MAX - 1'b1;
  state_t state, state_n;
  cpu_req_tx_pkg::cpu_to_control_req_if cmd, skid;
  logic push, enq, bad, pop, stall, to_ev;
  logic [TIMEOUT_W-1:0] stall_cnt;
  always_comb begin
    cmd = '{text_addr: cmd_text_addr, text_width: cmd_text_width, key_addr: cmd_key_addr,
            opcode: cmd_opcode, valid: 1'b1};
    cmd_ready = state != TWO;
    busy = state != EMPTY;
    push = cmd_valid && cmd_ready;
    enq = push && cmd_text_width != '0;
    bad = push && cmd_text_width == '0;
    pop = req_if.valid && req_ready;
    stall = req_if.valid && !req_ready;
    to_ev = stall && stall_cnt == T_PRE;
    state_n = state == EMPTY ? (enq ? ONE : EMPTY) :
              state == ONE   ? (enq && !pop ? TWO : !enq && pop ? EMPTY : ONE) :
                               (pop ? ONE : TWO);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      req_if <= '0;
      skid <= '0;
      stall_cnt <= '0;
      err_bad_cmd <= 1'b0;
      err_timeout <= 1'b0;
      issued_cnt <= '0;
    end else begin
      state <= state_n;
      if (enq && (state == EMPTY || (state == ONE && pop))) req_if <= cmd;
      else if (state == TWO && pop) req_if <= skid;
      else if (pop) req_if.valid <= 1'b0;
      if (enq && state == ONE && !pop) skid <= cmd;
      stall_cnt <= !stall ? '0 : stall_cnt == T_MAX ? T_MAX : stall_cnt + 1'b1;
      err_bad_cmd <= bad || (err_bad_cmd && !clr_err);
      err_timeout <= to_ev || (err_timeout && !clr_err);
      issued_cnt <= issued_cnt + 16'(pop);
    end
  end
endmodule

// File: tb/tb_cpu_req_tx.sv
// tb_cpu_req_tx: directed self-checking bench for cpu_req_tx with immediate assertions.
module tb_cpu_req_tx;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, req_ready = 1'b0, clr_err = 1'b0;
  logic cmd_ready, err_bad_cmd, err_timeout, busy;
  logic [9:0] cmd_text_addr = '0, cmd_key_addr = '0;
  logic [2:0] cmd_text_width = '0;
  logic [1:0] cmd_opcode = '0;
  logic [15:0] issued_cnt;
  cpu_req_tx_pkg::cpu_to_control_req_if req_if;
  int n_assert = 0, n_fail = 0;
  cpu_req_tx #(.TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_text_addr(cmd_text_addr), .cmd_text_width(cmd_text_width),
    .cmd_key_addr(cmd_key_addr), .cmd_opcode(cmd_opcode), .req_if(req_if),
    .req_ready(req_ready), .clr_err(clr_err), .err_bad_cmd(err_bad_cmd),
    .err_timeout(err_timeout), .busy(busy), .issued_cnt(issued_cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [9:0] ta, input logic [2:0] tw,
                                     input logic [9:0] ka, input logic [1:0] op, input logic v);
    return {6'd0, ta, tw, ka, op, v};
  endfunction
  task automatic cmd(input logic [9:0] ta, input logic [2:0] tw, input logic [9:0] ka,
                     input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_text_addr = ta;
    cmd_text_width = tw;
    cmd_key_addr = ka;
    cmd_opcode = op;
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_req_if", 32'(req_if), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_errs", {30'd0, err_bad_cmd, err_timeout}, 32'd0);
    chk("rst_issued", 32'(issued_cnt), 32'd0);
    cmd(10'h012, 3'd3, 10'h2A0, cpu_req_tx_pkg::AES_ENC);
    req_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t1_req", 32'(req_if), mk(10'h012, 3'd3, 10'h2A0, cpu_req_tx_pkg::AES_ENC, 1'b1));
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_issued0", 32'(issued_cnt), 32'd0);
    step();
    chk("t1_valid_off", 32'(req_if.valid), 32'd0);
    chk("t1_busy_off", 32'(busy), 32'd0);
    chk("t1_issued1", 32'(issued_cnt), 32'd1);
    req_ready = 1'b0;
    cmd(10'h001, 3'd1, 10'h011, 2'd0);
    step();
    chk("t2_ready_one", 32'(cmd_ready), 32'd1);
    cmd(10'h002, 3'd2, 10'h022, 2'd2);
    step();
    chk("t2_ready_full", 32'(cmd_ready), 32'd0);
    chk("t2_head_a", 32'(req_if), mk(10'h001, 3'd1, 10'h011, 2'd0, 1'b1));
    cmd(10'h003, 3'd7, 10'h033, 2'd3);
    step();
    chk("t2_hold_a", 32'(req_if), mk(10'h001, 3'd1, 10'h011, 2'd0, 1'b1));
    chk("t2_still_full", 32'(cmd_ready), 32'd0);
    req_ready = 1'b1;
    step();
    chk("t2_head_b", 32'(req_if), mk(10'h002, 3'd2, 10'h022, 2'd2, 1'b1));
    chk("t2_issued2", 32'(issued_cnt), 32'd2);
    step();
    cmd_valid = 1'b0;
    chk("t2_head_c", 32'(req_if), mk(10'h003, 3'd7, 10'h033, 2'd3, 1'b1));
    chk("t2_issued3", 32'(issued_cnt), 32'd3);
    step();
    chk("t2_drained", 32'(req_if.valid), 32'd0);
    chk("t2_issued4", 32'(issued_cnt), 32'd4);
    req_ready = 1'b0;
    cmd(10'h005, 3'd0, 10'h055, 2'd1);
    step();
    cmd_valid = 1'b0;
    chk("t3_ready", 32'(cmd_ready), 32'd1);
    chk("t3_no_valid", 32'(req_if.valid), 32'd0);
    chk("t3_bad_set", 32'(err_bad_cmd), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t3_bad_clr", 32'(err_bad_cmd), 32'd0);
    cmd(10'h006, 3'd0, 10'h066, 2'd1);
    clr_err = 1'b1;
    step();
    cmd_valid = 1'b0;
    clr_err = 1'b0;
    chk("t3_new_wins", 32'(err_bad_cmd), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t3_bad_clr2", 32'(err_bad_cmd), 32'd0);
    cmd(10'h3FF, 3'd4, 10'h155, 2'd1);
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("t4_no_timeout", 32'(err_timeout), 32'd0);
      chk("t4_held", 32'(req_if), mk(10'h3FF, 3'd4, 10'h155, 2'd1, 1'b1));
    end
    step();
    chk("t4_timeout", 32'(err_timeout), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_held_sat", 32'(req_if), mk(10'h3FF, 3'd4, 10'h155, 2'd1, 1'b1));
      chk("t4_sticky", 32'(err_timeout), 32'd1);
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("t4_issued", 32'(issued_cnt), 32'd5);
    chk("t4_gone", 32'(req_if.valid), 32'd0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t4_to_clr", 32'(err_timeout), 32'd0);
    cmd(10'h0E0, 3'd2, 10'h0E1, 2'd3);
    step();
    cmd(10'h0F0, 3'd5, 10'h0F1, 2'd2);
    step();
    cmd_valid = 1'b0;
    chk("t5_full", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid", 32'(req_if.valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_issued", 32'(issued_cnt), 32'd0);
    chk("t5_ready", 32'(cmd_ready), 32'd1);
    req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_stale", 32'(req_if.valid), 32'd0);
    end
    chk("t5_issued_still0", 32'(issued_cnt), 32'd0);
    cmd(10'h100, 3'd1, 10'h200, 2'd0);
    for (int i = 0; i < 65536; i++) step();
    chk("t6_ffff", 32'(issued_cnt), 32'h0000FFFF);
    step();
    chk("t6_wrap", 32'(issued_cnt), 32'd0);
    chk("t6_valid", 32'(req_if.valid), 32'd1);
    cmd_valid = 1'b0;
    step();
    chk("t6_after", 32'(issued_cnt), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
